mips_cpu_multdiv: RTL and testbench

- Multi-cycle multiply/divide engine that owns the architectural HI and LO registers.
- It is the producing end of the HI/LO path. It executes MULT, MULTU, DIV and DIVU iteratively, accepts MTHI/MTLO writes, and presents HI/LO to the datapath for MFHI/MFLO.
- Sits beside the ALU in the execute stage. The control unit stalls the CPU while `busy` is high.

---
 rtl/mips_cpu_multdiv.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mips_cpu_multdiv.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_multdiv.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Define MIPS_MULTDIV_MADD_EN to add SPECIAL2 MADD/MADDU/MSUB/MSUBU accumulation.
module mips_cpu_multdiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       insop,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  a_raw_q, a_raw_d;
    logic              is_div_q, is_div_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              dz_q, dz_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Instruction decode
    logic dec_special;
    logic dec_mult, dec_multu, dec_div, dec_divu, dec_mthi, dec_mtlo;
    logic dec_signed, dec_mul_any, dec_div_any, dec_md;

    assign dec_special = (insop == 6'b000000);
    assign dec_mult    = dec_special && (func == 6'b011000);
    assign dec_multu   = dec_special && (func == 6'b011001);
    assign dec_div     = dec_special && (func == 6'b011010);
    assign dec_divu    = dec_special && (func == 6'b011011);
    assign dec_mthi    = dec_special && (func == 6'b010001);
    assign dec_mtlo    = dec_special && (func == 6'b010011);
    assign dec_div_any = dec_div | dec_divu;

`ifdef MIPS_MULTDIV_MADD_EN
    logic dec_special2, dec_madd, dec_maddu, dec_msub, dec_msubu, dec_mac, dec_sub;
    logic mac_q, mac_d;
    logic msub_q, msub_d;

    assign dec_special2 = (insop == 6'b011100);
    assign dec_madd     = dec_special2 && (func == 6'b000000);
    assign dec_maddu    = dec_special2 && (func == 6'b000001);
    assign dec_msub     = dec_special2 && (func == 6'b000100);
    assign dec_msubu    = dec_special2 && (func == 6'b000101);
    assign dec_mac      = dec_madd | dec_maddu | dec_msub | dec_msubu;
    assign dec_sub      = dec_msub | dec_msubu;
    assign dec_signed   = dec_mult | dec_div | dec_madd | dec_msub;
    assign dec_mul_any  = dec_mult | dec_multu | dec_mac;
`else
    assign dec_signed   = dec_mult | dec_div;
    assign dec_mul_any  = dec_mult | dec_multu;
`endif

    assign dec_md = dec_mul_any | dec_div_any;

    // Operand magnitudes for signed ops
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = dec_signed & op_a[WIDTH-1];
    assign b_neg = dec_signed & op_b[WIDTH-1];
    assign a_mag = a_neg ? (~op_a + WIDTH'(1)) : op_a;
    assign b_mag = b_neg ? (~op_b + WIDTH'(1)) : op_b;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_s;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        opb_d    = opb_q;
        a_raw_d  = a_raw_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        prod     = '0;
        prod_s   = '0;
`ifdef MIPS_MULTDIV_MADD_EN
        mac_d    = mac_q;
        msub_d   = msub_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dec_md) begin
                        state_d  = dec_div_any ? S_DIV : S_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        busy_d   = 1'b1;
                        a_raw_d  = op_a;
                        is_div_d = dec_div_any;
                        dz_d     = (op_b == '0);
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                        // Divide shifts the dividend through sh; multiply shifts the multiplier
                        if (dec_div_any) begin
                            sh_d  = a_mag;
                            opb_d = b_mag;
                        end else begin
                            sh_d  = b_mag;
                            opb_d = a_mag;
                        end
`ifdef MIPS_MULTDIV_MADD_EN
                        mac_d  = dec_mac;
                        msub_d = dec_sub;
`endif
                    end else if (dec_mthi) begin
                        hi_d = op_a;
                    end else if (dec_mtlo) begin
                        lo_d = op_a;
                    end
                end
            end

            S_MUL: begin
                // {acc, sh} forms the running product; multiplier bits retire from sh[0]
                sum   = {1'b0, acc_q} + {1'b0, opb_q & {WIDTH{sh_q[0]}}};
                acc_d = sum[WIDTH:1];
                sh_d  = {sum[0], sh_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FINISH;
                end
            end

            S_DIV: begin
                shifted = {acc_q, sh_q[WIDTH-1]};
                diff    = shifted - {1'b0, opb_q};
                if (!diff[WIDTH]) begin
                    acc_d = diff[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                prod   = {acc_q, sh_q};
                prod_s = neg_lo_q ? (~prod + PW'(1)) : prod;
                if (is_div_q) begin
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = neg_lo_q ? (~sh_q + WIDTH'(1)) : sh_q;
                        hi_d = neg_hi_q ? (~acc_q + WIDTH'(1)) : acc_q;
                    end
                end else begin
`ifdef MIPS_MULTDIV_MADD_EN
                    if (mac_q) begin
                        {hi_d, lo_d} = msub_q ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
                    end else begin
                        {hi_d, lo_d} = prod_s;
                    end
`else
                    {hi_d, lo_d} = prod_s;
`endif
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opb_q    <= '0;
            a_raw_q  <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MIPS_MULTDIV_MADD_EN
            mac_q    <= 1'b0;
            msub_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opb_q    <= opb_d;
            a_raw_q  <= a_raw_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MIPS_MULTDIV_MADD_EN
            mac_q    <= mac_d;
            msub_q   <= msub_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_mips_cpu_multdiv.sv
// Bench for mips_cpu_multdiv: directed test-plan cases plus random traffic against
// an arithmetic reference model of HI/LO, busy and done.
module tb_mips_cpu_multdiv;

    localparam int unsigned W   = 32;
    localparam int          LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   insop;
    logic [5:0]   func;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    always #5 clk = ~clk;

    mips_cpu_multdiv #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .insop  (insop),
        .func   (func),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = no effect, 1 = mult/div class, 2 = MTHI, 3 = MTLO
    function automatic int decode(input logic [5:0] io, input logic [5:0] fn);
        if (io == 6'b000000) begin
            case (fn)
                6'b011000, 6'b011001, 6'b011010, 6'b011011: return 1;
                6'b010001: return 2;
                6'b010011: return 3;
                default:   return 0;
            endcase
        end
`ifdef MIPS_MULTDIV_MADD_EN
        if (io == 6'b011100 && (fn == 6'b000000 || fn == 6'b000001 ||
                                fn == 6'b000100 || fn == 6'b000101)) return 1;
`endif
        return 0;
    endfunction

    // Returns the final {HI, LO}
    function automatic logic [63:0] md_result(input logic [5:0] io, input logic [5:0] fn,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] hi, input logic [31:0] lo);
        logic signed [63:0] sa, sb, sq, sr, sp;
        logic [63:0]        ua, ub, uq, ur, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        sp = sa * sb;
        up = ua * ub;
        if (io == 6'b011100) begin
            case (fn)
                6'b000000: return {hi, lo} + sp;
                6'b000001: return {hi, lo} + up;
                6'b000100: return {hi, lo} - sp;
                default:   return {hi, lo} - up;
            endcase
        end
        case (fn)
            6'b011000: return sp;
            6'b011001: return up;
            6'b011010: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Reference model: a countdown to the moment the pending result lands
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    bit          m_busy = 1'b0, m_done = 1'b0;
    int          m_rem = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_rem  <= 0;
        end else if (m_rem > 0) begin
            m_rem  <= m_rem - 1;
            m_done <= 1'b0;
            if (m_rem == 1) begin
                m_hi   <= m_res[63:32];
                m_lo   <= m_res[31:0];
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                case (decode(insop, func))
                    1: begin
                        m_res  <= md_result(insop, func, op_a, op_b, m_hi, m_lo);
                        m_rem  <= LAT;
                        m_busy <= 1'b1;
                    end
                    2:       m_hi <= op_a;
                    3:       m_lo <= op_a;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {63'h0, busy}, {63'h0, m_busy});
            chk("done", {63'h0, done}, {63'h0, m_done});
            chk("hi",   {32'h0, hi_out}, {32'h0, m_hi});
            chk("lo",   {32'h0, lo_out}, {32'h0, m_lo});
        end
    end

    // Issue one op from a negedge; returns at the negedge where done is seen
    task automatic do_op(input logic [5:0] io, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         output int busy_cycles, output bit got_done);
        start = 1'b1; insop = io; func = fn; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        got_done = 1'b0;
        for (int i = 0; i < LAT + 8 && !got_done; i++) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
        chk("op_done_seen", {63'h0, got_done}, 64'h1);
    endtask

    task automatic mt_write(input logic [5:0] fn, input logic [31:0] a);
        start = 1'b1; insop = 6'b000000; func = fn; op_a = a; op_b = $urandom;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [11:0] rnd_code();
        case ($urandom_range(0, 11))
            0:       return {6'b000000, 6'b011000};
            1:       return {6'b000000, 6'b011001};
            2:       return {6'b000000, 6'b011010};
            3:       return {6'b000000, 6'b011011};
            4:       return {6'b000000, 6'b010001};
            5:       return {6'b000000, 6'b010011};
            6:       return {6'b011100, 6'b000000};
            7:       return {6'b011100, 6'b000001};
            8:       return {6'b011100, 6'b000100};
            9:       return {6'b011100, 6'b000101};
            10:      return {6'b000000, 6'b100000};
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        int          bc;
        bit          gd;
        bit          saw_done;
        logic [11:0] code;

        reset = 1'b0; start = 1'b0; insop = '0; func = '0; op_a = '0; op_b = '0;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        chk("reset_hilo", {hi_out, lo_out}, 64'h0);
        reset = 1'b1;
        @(negedge clk);

        do_op(6'b000000, 6'b011000, 32'hFFFF_FFFF, 32'h2, bc, gd);
        chk("mult_busy_cycles", 64'(bc), 64'd33);
        chk("mult_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(6'b000000, 6'b011001, 32'hFFFF_FFFF, 32'h2, bc, gd);
        chk("multu_done_pulse_prev", {63'h0, done}, 64'h1);
        chk("multu_hilo", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFE);
        do_op(6'b000000, 6'b011011, 32'd100, 32'd7, bc, gd);
        chk("divu_hilo", {hi_out, lo_out}, {32'd2, 32'd14});
        chk("divu_busy_cycles", 64'(bc), 64'd33);
        do_op(6'b000000, 6'b011010, 32'hFFFF_FFF9, 32'h2, bc, gd);
        chk("div_neg_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(6'b000000, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, bc, gd);
        chk("div_ovf_hilo", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
        do_op(6'b000000, 6'b011011, 32'd7, 32'd0, bc, gd);
        chk("divu_zero_hilo", {hi_out, lo_out}, {32'd7, 32'hFFFF_FFFF});
        chk("divz_busy_cycles", 64'(bc), 64'd33);
        mt_write(6'b010011, 32'h1234);
        chk("mtlo_hilo", {hi_out, lo_out}, {32'd7, 32'h1234});
        chk("mtlo_busy", {63'h0, busy}, 64'h0);

        // MTHI while busy is dropped; reset mid-operation aborts it
        start = 1'b1; insop = 6'b000000; func = 6'b011000; op_a = 32'd3; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        mt_write(6'b010001, 32'h0000_AAAA);
        repeat (8) @(negedge clk);
        chk("busy_mthi_ignored", {32'h0, hi_out}, 64'd7);
        chk("busy_mid_op", {63'h0, busy}, 64'h1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_hilo", {hi_out, lo_out}, 64'h0);
        chk("abort_busy", {63'h0, busy}, 64'h0);
        saw_done = 1'b0;
        repeat (LAT + 8) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", {63'h0, saw_done}, 64'h0);

`ifdef MIPS_MULTDIV_MADD_EN
        mt_write(6'b010001, 32'h0);
        mt_write(6'b010011, 32'hFFFF_FFFF);
        do_op(6'b011100, 6'b000001, 32'd1, 32'd1, bc, gd);
        chk("maddu_hilo", {hi_out, lo_out}, 64'h0000_0001_0000_0000);
        do_op(6'b011100, 6'b000100, 32'd1, 32'd1, bc, gd);
        chk("msub_hilo", {hi_out, lo_out}, 64'h0000_0000_FFFF_FFFF);
`else
        do_op(6'b000000, 6'b011010, 32'd20, 32'hFFFF_FFFA, bc, gd);
        chk("div_negdiv_hilo", {hi_out, lo_out}, {32'd2, 32'hFFFF_FFFD});
        @(negedge clk);
        mt_write(6'b010001, 32'h5);
        start = 1'b1; insop = 6'b011100; func = 6'b000001; op_a = 32'd1; op_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("special2_ignored_busy", {63'h0, busy}, 64'h0);
        chk("special2_ignored_hilo", {hi_out, lo_out}, {32'h5, 32'hFFFF_FFFD});
`endif

        // Random traffic: back-to-back starts, starts while busy, rare resets
        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset = ($urandom_range(0, 499) != 0);
            start = ($urandom_range(0, 2) == 0);
            code  = rnd_code();
            insop = code[11:6];
            func  = code[5:0];
            op_a  = rnd_operand();
            op_b  = rnd_operand();
            @(negedge clk);
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (LAT + 4) @(negedge clk);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
